// File: rtl/brnch_pkg.sv
// rtl/brnch_pkg.sv - shared types and constants for the branch resolution controller
package brnch_pkg;

    typedef enum logic [1:0] {
        COND = 2'b00,
        JAL  = 2'b01,
        JALR = 2'b10
    } br_kind_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RESOLVE  = 2'b01,
        REDIRECT = 2'b10
    } state_e;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [1:0] BHT_INIT = 2'b01;

    // Encoding 11 is reserved and behaves as a conditional branch.
    function automatic br_kind_e decode_kind(input logic [1:0] raw);
        case (raw)
            2'b01:   return JAL;
            2'b10:   return JALR;
            default: return COND;
        endcase
    endfunction

endpackage

// File: rtl/brnch_ctrl_if.sv
// rtl/brnch_ctrl_if.sv - branch request and redirect bundle between EX, controller and fetch
// master: EX/fetch side (drives requests and redirect ready)
// slave : controller side (drives br_ready, redirect valid/pc and flush)
interface brnch_ctrl_if;
    logic        br_valid;
    logic        br_ready;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic [31:0] br_rs1;
    logic [31:0] br_rs2;
    logic [2:0]  br_funct3;
    logic [1:0]  br_kind;
    logic        br_pred_tk;
    logic        rdr_valid;
    logic        rdr_ready;
    logic [31:0] rdr_pc;
    logic        flush;

    modport master (
        output br_valid, br_pc, br_imm, br_rs1, br_rs2, br_funct3, br_kind, br_pred_tk, rdr_ready,
        input  br_ready, rdr_valid, rdr_pc, flush
    );

    modport slave (
        input  br_valid, br_pc, br_imm, br_rs1, br_rs2, br_funct3, br_kind, br_pred_tk, rdr_ready,
        output br_ready, rdr_valid, rdr_pc, flush
    );
endinterface

// File: rtl/brnch_bht.sv
// rtl/brnch_bht.sv - 2-bit bimodal branch history table
// rd_idx_i/rd_cnt_o: async lookup; upd_en_i/upd_idx_i/upd_tk_i: saturating train on clk_i
module brnch_bht
    import brnch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_tk_i
);
    logic [1:0] cnt_q [2**IDX_W];
    logic [1:0] upd_cur;
    logic [1:0] upd_nxt;

    // Lookup sees the registered value, so a same-cycle update is not bypassed.
    assign rd_cnt_o = cnt_q[rd_idx_i];
    assign upd_cur  = cnt_q[upd_idx_i];

    always_comb begin
        upd_nxt = upd_cur;
        if (upd_tk_i) begin
            if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2**IDX_W; i++) cnt_q[i] <= BHT_INIT;
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= upd_nxt;
        end
    end
endmodule

// File: rtl/brnch_cmp.sv
// rtl/brnch_cmp.sv - branch compare unit
// a_i/b_i: operands, op_i: funct3, taken_o: compare result (0 for unsupported ops)
module brnch_cmp
    import brnch_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  op_i,
    output logic        taken_o
);
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            BEQ:     taken_o = (a_i == b_i);
            BNE:     taken_o = (a_i != b_i);
            BLT:     taken_o = ($signed(a_i) <  $signed(b_i));
            BGE:     taken_o = ($signed(a_i) >= $signed(b_i));
            BLTU:    taken_o = (a_i <  b_i);
            BGEU:    taken_o = (a_i >= b_i);
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/brnch_ctrl.sv
// rtl/brnch_ctrl.sv - branch resolution controller: resolve, train BHT, redirect and flush fetch
// clk_i/rst_ni: clock, async active-low reset; br: request/redirect bundle (slave side)
// pred_pc_i/pred_tk_o: fetch direction lookup; mispred_cnt_o: saturating mispredict count
module brnch_ctrl
    import brnch_pkg::*;
#(
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    brnch_ctrl_if.slave        br,
    input  logic [31:0]        pred_pc_i,
    output logic               pred_tk_o,
    output logic [CNT_W-1:0]   mispred_cnt_o
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, imm_q, rs1_q, rs2_q;
    logic [2:0]  f3_q;
    br_kind_e    kind_q;
    logic        pred_q;
    logic [31:0] rdr_pc_q, rdr_pc_d;
    logic        flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        accept;
    logic        cmp_tk;
    logic        actual_tk;
    logic        mispred;
    logic [31:0] target;
    logic [31:0] rdr_target;
    logic [1:0]  lookup_cnt;
    logic        unused_bits;

    assign accept      = br.br_valid && (state_q == IDLE);
    assign br.br_ready = (state_q == IDLE);
    assign br.rdr_valid = (state_q == REDIRECT);
    assign br.rdr_pc   = rdr_pc_q;
    assign br.flush    = flush_q;
    assign mispred_cnt_o = cnt_q;

    brnch_cmp u_cmp (
        .a_i     (rs1_q),
        .b_i     (rs2_q),
        .op_i    (f3_q),
        .taken_o (cmp_tk)
    );

    brnch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_idx_i  (pred_pc_i[BHT_IDX_W+1:2]),
        .rd_cnt_o  (lookup_cnt),
        .upd_en_i  ((state_q == RESOLVE) && (kind_q == COND)),
        .upd_idx_i (pc_q[BHT_IDX_W+1:2]),
        .upd_tk_i  (cmp_tk)
    );

    assign pred_tk_o   = lookup_cnt[1];
    assign unused_bits = ^{pred_pc_i[31:BHT_IDX_W+2], pred_pc_i[1:0], lookup_cnt[0]};

    assign actual_tk  = (kind_q == COND) ? cmp_tk : 1'b1;
    assign target     = (kind_q == JALR) ? ((rs1_q + imm_q) & ~32'd1) : (pc_q + imm_q);
    // JALR targets are never predicted by fetch, so they always redirect.
    assign mispred    = (actual_tk != pred_q) || (kind_q == JALR);
    assign rdr_target = actual_tk ? target : (pc_q + 32'd4);

    always_comb begin
        state_d  = state_q;
        rdr_pc_d = rdr_pc_q;
        flush_d  = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = RESOLVE;
            end
            RESOLVE: begin
                if (mispred) begin
                    rdr_pc_d = rdr_target;
                    flush_d  = 1'b1;
                    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    state_d  = REDIRECT;
                end else begin
                    state_d  = IDLE;
                end
            end
            REDIRECT: begin
                if (br.rdr_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rdr_pc_q <= '0;
            flush_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdr_pc_q <= rdr_pc_d;
            flush_q  <= flush_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= '0;
            imm_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            f3_q   <= '0;
            kind_q <= COND;
            pred_q <= 1'b0;
        end else if (accept) begin
            pc_q   <= br.br_pc;
            imm_q  <= br.br_imm;
            rs1_q  <= br.br_rs1;
            rs2_q  <= br.br_rs2;
            f3_q   <= br.br_funct3;
            kind_q <= decode_kind(br.br_kind);
            pred_q <= br.br_pred_tk;
        end
    end
endmodule

// File: tb/tb_brnch_ctrl.sv
// tb/tb_brnch_ctrl.sv - scoreboard bench for brnch_ctrl
module tb_brnch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_tk;
    logic [15:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_flush = 0;
    logic prev_flush = 1'b0;
    logic [31:0] exp_q[$];

    brnch_ctrl_if bus();

    brnch_ctrl #(.BHT_IDX_W(6), .CNT_W(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .br            (bus),
        .pred_pc_i     (pred_pc),
        .pred_tk_o     (pred_tk),
        .mispred_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge (RESOLVE cycle).
    task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [2:0] f3, input logic [1:0] kind,
                         input logic ptk);
        int w = 0;
        while (!bus.br_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.br_ready) begin
            chk("issue_ready_timeout", {31'd0, bus.br_ready}, 32'd1);
            return;
        end
        bus.br_pc = pc; bus.br_imm = imm; bus.br_rs1 = rs1; bus.br_rs2 = rs2;
        bus.br_funct3 = f3; bus.br_kind = kind; bus.br_pred_tk = ptk;
        bus.br_valid = 1'b1;
        @(negedge clk);
        bus.br_valid = 1'b0;
    endtask

    // Monitor: pops the expected redirect PC on every redirect handshake and polices flush.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_flush = 1'b0;
            end else begin
                if (bus.rdr_valid && bus.rdr_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rdr_unexpected: got redirect 0x%08h expected none", bus.rdr_pc);
                    end else begin
                        chk("rdr_pc", bus.rdr_pc, exp_q.pop_front());
                    end
                end
                if (bus.flush) begin
                    n_flush++;
                    chk("flush_with_valid", {31'd0, bus.rdr_valid}, 32'd1);
                    chk("flush_single_cycle", {31'd0, prev_flush}, 32'd0);
                end
                prev_flush = bus.flush;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ep;
        rst_n = 1'b0;
        pred_pc = 32'h104;
        bus.br_valid = 1'b0; bus.br_pc = '0; bus.br_imm = '0; bus.br_rs1 = '0; bus.br_rs2 = '0;
        bus.br_funct3 = '0; bus.br_kind = '0; bus.br_pred_tk = 1'b0; bus.rdr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_br_ready", {31'd0, bus.br_ready}, 32'd1);
        chk("rst_rdr_valid", {31'd0, bus.rdr_valid}, 32'd0);
        chk("rst_rdr_pc", bus.rdr_pc, 32'd0);
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        chk("rst_pred", {31'd0, pred_tk}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // BEQ taken, predicted not-taken -> redirect to 0x124
        exp_q.push_back(32'h124);
        issue(32'h104, 32'h20, 32'd5, 32'd5, 3'b000, 2'b00, 1'b0);
        chk("beq_resolve_ready", {31'd0, bus.br_ready}, 32'd0);
        chk("lookup_in_resolve", {31'd0, pred_tk}, 32'd0);
        @(negedge clk);
        chk("beq_rdr_valid", {31'd0, bus.rdr_valid}, 32'd1);
        chk("beq_flush", {31'd0, bus.flush}, 32'd1);
        chk("beq_cnt", {16'd0, cnt}, 32'd1);
        chk("lookup_after_update", {31'd0, pred_tk}, 32'd1);
        @(negedge clk);
        chk("beq_rdr_drop", {31'd0, bus.rdr_valid}, 32'd0);
        chk("beq_flush_drop", {31'd0, bus.flush}, 32'd0);
        chk("beq_ready_back", {31'd0, bus.br_ready}, 32'd1);

        // BLTU 0xFFFFFFFF < 1 unsigned is false -> correctly predicted not-taken
        issue(32'h208, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'b110, 2'b00, 1'b0);
        chk("bltu_resolve_ready", {31'd0, bus.br_ready}, 32'd0);
        @(negedge clk);
        chk("bltu_ready_n2", {31'd0, bus.br_ready}, 32'd1);
        chk("bltu_no_rdr", {31'd0, bus.rdr_valid}, 32'd0);
        chk("bltu_cnt", {16'd0, cnt}, 32'd1);

        // JALR (0x1003+4)&~1 = 0x1006, fetch stalls the redirect 3 cycles
        bus.rdr_ready = 1'b0;
        exp_q.push_back(32'h1006);
        issue(32'h400, 32'd4, 32'h1003, 32'd0, 3'b000, 2'b10, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("jalr_valid_hold", {31'd0, bus.rdr_valid}, 32'd1);
            chk("jalr_pc_hold", bus.rdr_pc, 32'h1006);
            chk("jalr_no_accept", {31'd0, bus.br_ready}, 32'd0);
            if (k == 0) begin
                bus.br_pc = 32'h500; bus.br_kind = 2'b00; bus.br_funct3 = 3'b000;
                bus.br_rs1 = 32'd1; bus.br_rs2 = 32'd1; bus.br_pred_tk = 1'b0;
                bus.br_valid = 1'b1;
            end
            if (k < 3) @(negedge clk);
        end
        bus.br_valid = 1'b0;
        bus.rdr_ready = 1'b1;
        @(negedge clk);
        chk("jalr_rdr_drop", {31'd0, bus.rdr_valid}, 32'd0);
        chk("jalr_cnt", {16'd0, cnt}, 32'd2);
        @(negedge clk);
        chk("jalr_stray_ignored", {31'd0, bus.br_ready}, 32'd1);

        // Same taken BNE four times at 0x30C: 01->10->11->11
        for (int i = 0; i < 4; i++) begin
            pred_pc = 32'h30C;
            #1;
            ep = (i == 0) ? 1'b0 : 1'b1;
            chk("rep_pred_before", {31'd0, pred_tk}, {31'd0, ep});
            if (!ep) exp_q.push_back(32'h34C);
            issue(32'h30C, 32'h40, 32'd1, 32'd2, 3'b001, 2'b00, ep);
            @(negedge clk);
            chk("rep_pred_after", {31'd0, pred_tk}, 32'd1);
            chk("rep_cnt", {16'd0, cnt}, 32'd3);
        end

        // Reset while a redirect is pending
        @(negedge clk);
        bus.rdr_ready = 1'b0;
        exp_q.push_back(32'h240);
        issue(32'h208, 32'h38, 32'd7, 32'd7, 3'b000, 2'b00, 1'b0);
        @(negedge clk);
        chk("mid_rdr_valid", {31'd0, bus.rdr_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdr_valid", {31'd0, bus.rdr_valid}, 32'd0);
        chk("async_rst_cnt", {16'd0, cnt}, 32'd0);
        chk("async_rst_rdr_pc", bus.rdr_pc, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.rdr_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.br_ready}, 32'd1);
        pred_pc = 32'h104;
        #1;
        chk("post_rst_pred_104", {31'd0, pred_tk}, 32'd0);
        pred_pc = 32'h30C;
        #1;
        chk("post_rst_pred_30c", {31'd0, pred_tk}, 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        chk("flush_count", n_flush, 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/brnch_ctrl.md
Name: brnch_ctrl

Overview:
Branch resolution controller between the EX stage and the fetch unit. It accepts one branch or jump per handshake and drives the existing branch compare unit with registered operands. It resolves the actual direction and target, trains a 2-bit bimodal branch history table (BHT), and issues a PC redirect plus a flush on misprediction. The BHT also serves a combinational direction-lookup port to fetch.

Parameters:
BHT_IDX_W, 6, log2 of BHT entry count (64 entries); index = pc[BHT_IDX_W+1:2]
CNT_W, 16, width of the saturating mispredict counter

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  asynchronous, active-low reset
br_valid_i  in  1  branch request valid from EX
br_ready_o  out  1  controller can accept a request
br_pc_i  in  32  PC of the branch
br_imm_i  in  32  sign-extended immediate
br_rs1_i  in  32  rs1 operand
br_rs2_i  in  32  rs2 operand
br_funct3_i  in  3  funct3; passed as compare op
br_kind_i  in  2  00 COND, 01 JAL, 10 JALR, 11 reserved (treated as COND)
br_pred_tk_i  in  1  direction fetch predicted for this branch
pred_pc_i  in  32  fetch lookup PC
pred_tk_o  out  1  BHT prediction for pred_pc_i (combinational)
rdr_valid_o  out  1  redirect request to fetch
rdr_ready_i  in  1  fetch accepts redirect
rdr_pc_o  out  32  redirect PC
flush_o  out  1  one-cycle pulse: squash younger instructions
mispred_cnt_o  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, rst_ni=0): state IDLE; br_ready_o=1, rdr_valid_o=0, rdr_pc_o=0, flush_o=0, mispred_cnt_o=0. All BHT entries = 2'b01 (weakly not-taken). Applies immediately, including mid-RESOLVE or mid-REDIRECT; the pending request is dropped.
- States: IDLE, RESOLVE, REDIRECT. br_ready_o = (state==IDLE).
- IDLE: on br_valid_i && br_ready_o, capture pc, imm, rs1, rs2, funct3, kind and pred_tk into registers, then go to RESOLVE. No acceptance in any other state.
- RESOLVE (exactly one cycle): compare unit is fed from the captured registers.
  - actual_tk = compare result for COND; 1 for JAL and JALR.
  - Target = pc+imm for COND/JAL; (rs1+imm) & ~1 for JALR. Arithmetic is 32-bit modulo; wrap-around is ignored.
  - Unsupported funct3 (010, 011): the compare unit yields 0, so the branch resolves not-taken.
  - mispredict = (actual_tk != pred_tk) || (kind==JALR).
  - Redirect PC = actual_tk ? target : pc+4.
  - BHT update for COND only: counter +1 if taken, -1 if not taken, saturating at 00/11.
  - If mispredict: load rdr_pc_o, increment mispred_cnt_o (saturating at all ones), go to REDIRECT. Otherwise return to IDLE.
- REDIRECT: rdr_valid_o=1 and rdr_pc_o held stable until rdr_ready_i. flush_o=1 only in the first REDIRECT cycle. When rdr_valid_o && rdr_ready_i, go to IDLE and drop rdr_valid_o on the next cycle.
- Latency: accept in cycle N, resolve in N+1, rdr_valid_o and flush_o asserted in N+2. Throughput is one branch per 2 cycles when predicted correctly.
- pred_tk_o = MSB of BHT[pred_pc_i idx]. Lookup and update to the same index in the same cycle: lookup returns the pre-update value (no bypass).

Decomposition:
- brnch_pkg holds:
  - br_kind_e enum (COND, JAL, JALR)
  - state enum (IDLE, RESOLVE, REDIRECT)
  - funct3 constants (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111)
  - BHT_INIT = 2'b01
- Instantiates the existing compare unit unchanged.
- One natural sub-module: brnch_bht, the counter array with one async-read port, one update port and async reset init.

Test Plan:
- Reset mid-REDIRECT (pull rst_ni low while rdr_valid_o=1) -> rdr_valid_o=0 immediately; br_ready_o=1 after release; pred_tk_o=0 for any PC.
- COND BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred_tk=0 -> rdr_pc_o=0x120; flush_o high for 1 cycle at N+2; mispred_cnt_o=1; BHT[0x100 idx] goes 01->10.
- COND BLTU, rs1=0xFFFF_FFFF, rs2=1, pred_tk=0 -> not taken; no redirect; state back to IDLE at N+2; br_ready_o high at N+2.
- JALR, rs1=0x1003, imm=4, pred_tk=1, rdr_ready_i held 0 for 3 cycles -> rdr_pc_o=0x1006 stable for 4 cycles; flush_o pulsed only once; br_valid_i ignored until the handshake completes.
- Same taken COND branch issued 4 times -> counter goes 01->10->11->11 (saturates); pred_tk_o=1 from the second resolve onward; mispred_cnt_o stops counting once predictions are correct.
- Lookup pred_pc_i equal to the branch PC during its RESOLVE cycle -> pred_tk_o shows the old counter value that cycle and the new value the next cycle.
